// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: pulls bytes from the UART receiver over a ready/clear
// handshake, assembles 5-byte frames (sync, addr, data hi, data lo, checksum)
// and issues one register-write strobe per frame whose checksum matches.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        uart_cmd_clk,
  input  logic        uart_cmd_rst,
  input  logic [7:0]  uart_cmd_rx_data,
  input  logic        uart_cmd_rx_rdy,
  output logic        uart_cmd_rx_clr,
  output logic        uart_cmd_wr_en,
  output logic [7:0]  uart_cmd_wr_addr,
  output logic [15:0] uart_cmd_wr_data,
  output logic        uart_cmd_busy,
  output logic        uart_cmd_err_csum,
  output logic        uart_cmd_err_tmo,
  output logic [7:0]  uart_cmd_err_cnt
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       ERR_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
    S_DLO  = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic             clr_q, clr_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             err_csum_q, err_csum_d;
  logic             err_tmo_q, err_tmo_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             accept;

  // A byte is taken only when the receiver offers one and no clear is pending
  assign accept = uart_cmd_rx_rdy & ~clr_q;

  // Next-state, handshake, timeout and output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    acc_d      = acc_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    clr_d      = clr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_csum_d = 1'b0;
    err_tmo_d  = 1'b0;
    err_cnt_d  = err_cnt_q;

    // Clear is raised on accept and released once the receiver drops ready
    if (accept) begin
      clr_d = 1'b1;
    end else if (clr_q && !uart_cmd_rx_rdy) begin
      clr_d = 1'b0;
    end

    if (accept || (state_q == S_SYNC)) begin
      cnt_d = '0;
    end

    case (state_q)
      S_SYNC: begin
        if (accept && (uart_cmd_rx_data == SYNC_BYTE)) begin
          acc_d   = 8'h00;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = uart_cmd_rx_data;
          acc_d   = uart_cmd_rx_data;
          state_d = S_DHI;
        end
      end
      S_DHI: begin
        if (accept) begin
          hi_d    = uart_cmd_rx_data;
          acc_d   = acc_q + uart_cmd_rx_data;
          state_d = S_DLO;
        end
      end
      S_DLO: begin
        if (accept) begin
          lo_d    = uart_cmd_rx_data;
          acc_d   = acc_q + uart_cmd_rx_data;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (uart_cmd_rx_data == acc_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {hi_q, lo_q};
          end else begin
            err_csum_d = 1'b1;
          end
          state_d = S_SYNC;
        end
      end
      default: state_d = S_SYNC;
    endcase

    // Inter-byte timeout; a byte arriving on the terminal count wins
    if ((state_q != S_SYNC) && !accept && (cnt_q == TMO_LAST)) begin
      state_d   = S_SYNC;
      err_tmo_d = 1'b1;
      cnt_d     = '0;
    end

    // Saturating error counter
    if ((err_csum_d || err_tmo_d) && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge uart_cmd_clk) begin
    if (uart_cmd_rst) begin
      state_q    <= S_SYNC;
      cnt_q      <= '0;
      acc_q      <= 8'h00;
      addr_q     <= 8'h00;
      hi_q       <= 8'h00;
      lo_q       <= 8'h00;
      clr_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 16'h0000;
      err_csum_q <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      clr_q      <= clr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_csum_q <= err_csum_d;
      err_tmo_q  <= err_tmo_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign uart_cmd_rx_clr   = clr_q;
  assign uart_cmd_wr_en    = wr_en_q;
  assign uart_cmd_wr_addr  = wr_addr_q;
  assign uart_cmd_wr_data  = wr_data_q;
  assign uart_cmd_err_csum = err_csum_q;
  assign uart_cmd_err_tmo  = err_tmo_q;
  assign uart_cmd_err_cnt  = err_cnt_q;
  // busy is a direct decode of the state register
  assign uart_cmd_busy     = (state_q != S_SYNC);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: a receiver model drives bytes over the
// ready/clear handshake; expected write/error events go to a scoreboard queue.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_clr;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        err_csum;
  logic        err_tmo;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic [1:0]  kind;  // 1 write, 2 checksum error, 3 timeout
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  m_e;
  logic [1:0] m_kind;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_err_cnt = 0;
  int   last_acc = 0;

  uart_cmd_parser #(
    .SYNC_BYTE(8'h55),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(16)
  ) dut (
    .uart_cmd_clk(clk),
    .uart_cmd_rst(rst),
    .uart_cmd_rx_data(rx_data),
    .uart_cmd_rx_rdy(rx_rdy),
    .uart_cmd_rx_clr(rx_clr),
    .uart_cmd_wr_en(wr_en),
    .uart_cmd_wr_addr(wr_addr),
    .uart_cmd_wr_data(wr_data),
    .uart_cmd_busy(busy),
    .uart_cmd_err_csum(err_csum),
    .uart_cmd_err_tmo(err_tmo),
    .uart_cmd_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe or error pulse must match the next expected event
  always @(negedge clk) begin
    if (!rst && (wr_en || err_csum || err_tmo)) begin
      m_kind = wr_en ? 2'd1 : (err_csum ? 2'd2 : 2'd3);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got kind=%0d addr=%h data=%h exp nothing", m_kind, wr_addr, wr_data);
      end else begin
        m_e = exp_q.pop_front();
        if ((m_kind !== m_e.kind) || ((wr_en + err_csum + err_tmo) != 1) ||
            (m_e.kind == 2'd1 && (wr_addr !== m_e.addr || wr_data !== m_e.data))) begin
          bad++;
          $display("FAIL sb_event got kind=%0d addr=%h data=%h exp kind=%0d addr=%h data=%h",
                   m_kind, wr_addr, wr_data, m_e.kind, m_e.addr, m_e.data);
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = 2'd1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] k);
    ev_t e;
    e.kind = k; e.addr = 8'h00; e.data = 16'h0000;
    exp_q.push_back(e);
    if (exp_err_cnt < 255) exp_err_cnt++;
  endtask

  // Offer a byte at a negedge with clr low; hold ready for 'hold' cycles with clr high
  task automatic drive_byte(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk); #1;
    last_acc = cyc;
    total++;
    if (rx_clr !== 1'b1) begin
      bad++; $display("FAIL clr_set got=%b exp=1", rx_clr);
    end
    repeat (hold) begin
      @(posedge clk); #1;
      total++;
      if (rx_clr !== 1'b1) begin
        bad++; $display("FAIL clr_hold got=%b exp=1", rx_clr);
      end
    end
    @(negedge clk);
    rx_rdy = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rx_clr !== 1'b0) begin
      bad++; $display("FAIL clr_drop got=%b exp=0", rx_clr);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    int h;
    h = (hold == 0) ? int'($urandom_range(1, 2)) : hold;
    for (int i = 0; i < 100 && rx_clr; i++) @(negedge clk);
    @(negedge clk);
    if (rx_clr) begin
      total++; bad++;
      $display("FAIL clr_wait got=1 exp=0");
    end
    drive_byte(b, h);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] cs, input int hold);
    logic [7:0] sum;
    sum = a + hi + lo;
    if (cs == sum) push_wr(a, {hi, lo});
    else push_err(2'd2);
    send_byte(8'h55, hold);
    send_byte(a, hold);
    send_byte(hi, hold);
    send_byte(lo, hold);
    send_byte(cs, hold);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rx_clr, wr_en, wr_addr, wr_data, busy, err_csum, err_tmo, err_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got clr=%b wr=%b a=%h d=%h busy=%b ec=%b et=%b cnt=%0d exp all 0",
               rx_clr, wr_en, wr_addr, wr_data, busy, err_csum, err_tmo, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_write;
    send_frame(8'h12, 8'hAB, 8'hCD, 8'h8A, 0);
    total++;
    if (wr_addr !== 8'h12 || wr_data !== 16'hABCD) begin
      bad++; $display("FAIL basic_wr got a=%h d=%h exp a=12 d=abcd", wr_addr, wr_data);
    end
    total++;
    if (err_cnt !== 8'(exp_err_cnt) || busy !== 1'b0) begin
      bad++; $display("FAIL basic_state got cnt=%0d busy=%b exp cnt=%0d busy=0", err_cnt, busy, exp_err_cnt);
    end
  endtask

  task automatic test_csum;
    send_frame(8'h01, 8'h00, 8'h00, 8'h02, 0);
    total++;
    if (err_cnt !== 8'd1) begin
      bad++; $display("FAIL csum_cnt got=%0d exp=1", err_cnt);
    end
    total++;
    if (wr_addr !== 8'h12 || wr_data !== 16'hABCD) begin
      bad++; $display("FAIL csum_hold got a=%h d=%h exp a=12 d=abcd", wr_addr, wr_data);
    end
    send_frame(8'h01, 8'h00, 8'h05, 8'h06, 0);
    total++;
    if (wr_addr !== 8'h01 || wr_data !== 16'h0005) begin
      bad++; $display("FAIL csum_next got a=%h d=%h exp a=01 d=0005", wr_addr, wr_data);
    end
  endtask

  task automatic test_stray;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    total++;
    if (busy !== 1'b0 || err_cnt !== 8'(exp_err_cnt)) begin
      bad++; $display("FAIL stray_discard got busy=%b cnt=%0d exp busy=0 cnt=%0d", busy, err_cnt, exp_err_cnt);
    end
    send_frame(8'h7F, 8'hFF, 8'hFF, 8'h7D, 0);
    total++;
    if (wr_addr !== 8'h7F || wr_data !== 16'hFFFF) begin
      bad++; $display("FAIL stray_frame got a=%h d=%h exp a=7f d=ffff", wr_addr, wr_data);
    end
  endtask

  task automatic test_sync_in_data;
    send_frame(8'h55, 8'h55, 8'h55, 8'hFF, 0);
    total++;
    if (wr_addr !== 8'h55 || wr_data !== 16'h5555 || busy !== 1'b0) begin
      bad++; $display("FAIL sync_data got a=%h d=%h busy=%b exp a=55 d=5555 busy=0", wr_addr, wr_data, busy);
    end
  endtask

  task automatic test_handshake;
    send_frame(8'h3C, 8'h01, 8'h02, 8'h3F, 2);
    send_frame(8'h40, 8'h10, 8'h20, 8'h70, 1);
    total++;
    if (wr_addr !== 8'h40 || wr_data !== 16'h1020 || exp_q.size() != 0) begin
      bad++; $display("FAIL handshake got a=%h d=%h pend=%0d exp a=40 d=1020 pend=0", wr_addr, wr_data, exp_q.size());
    end
  endtask

  task automatic test_timeout;
    int e;
    send_byte(8'h55, 1);
    send_byte(8'h10, 1);
    e = last_acc;
    push_err(2'd3);
    while (cyc < e + int'(TO)) begin @(posedge clk); #1; end
    total++;
    if (err_tmo !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL tmo_fire got tmo=%b busy=%b exp tmo=1 busy=0", err_tmo, busy);
    end
    @(posedge clk); #1;
    total++;
    if (err_cnt !== 8'(exp_err_cnt) || err_tmo !== 1'b0) begin
      bad++; $display("FAIL tmo_cnt got cnt=%0d tmo=%b exp cnt=%0d tmo=0", err_cnt, err_tmo, exp_err_cnt);
    end
    // byte arriving on the terminal count must not time out
    send_byte(8'h55, 1);
    send_byte(8'h10, 1);
    e = last_acc;
    while (cyc < e + int'(TO) - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    drive_byte(8'h20, 1);
    total++;
    if (busy !== 1'b1 || err_cnt !== 8'(exp_err_cnt)) begin
      bad++; $display("FAIL tmo_edge got busy=%b cnt=%0d exp busy=1 cnt=%0d", busy, err_cnt, exp_err_cnt);
    end
    push_wr(8'h10, 16'h2030);
    send_byte(8'h30, 1);
    send_byte(8'h60, 1);
    total++;
    if (wr_addr !== 8'h10 || wr_data !== 16'h2030) begin
      bad++; $display("FAIL tmo_frame got a=%h d=%h exp a=10 d=2030", wr_addr, wr_data);
    end
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'h55, 1);
    send_byte(8'h20, 1);
    @(negedge clk);
    rx_data = 8'h33; rx_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_err_cnt = 0;
    total++;
    if (rx_clr !== 1'b0 || busy !== 1'b0 || wr_addr !== 8'h00 || wr_data !== 16'h0000 || err_cnt !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid got clr=%b busy=%b a=%h d=%h cnt=%0d exp all 0", rx_clr, busy, wr_addr, wr_data, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0; rx_rdy = 1'b0;
    send_frame(8'h20, 8'h00, 8'h01, 8'h21, 0);
    total++;
    if (wr_addr !== 8'h20 || wr_data !== 16'h0001 || err_cnt !== 8'h00) begin
      bad++; $display("FAIL rst_frame got a=%h d=%h cnt=%0d exp a=20 d=0001 cnt=0", wr_addr, wr_data, err_cnt);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h00, 8'h00, 8'h00, 8'h01, 1);
      if (i == 253 || i == 254 || i == 299) begin
        total++;
        if (err_cnt !== 8'(exp_err_cnt)) begin
          bad++; $display("FAIL sat_cnt frame=%0d got=%0d exp=%0d", i, err_cnt, exp_err_cnt);
        end
      end
    end
    total++;
    if (err_cnt !== 8'hFF || exp_q.size() != 0) begin
      bad++; $display("FAIL sat_final got cnt=%0d pend=%0d exp cnt=255 pend=0", err_cnt, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_csum();
    test_stray();
    test_sync_in_data();
    test_handshake();
    test_timeout();
    test_reset_mid_frame();
    test_saturate();
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_drain got pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
